fft_bitrev_reorder: RTL

//  Streaming output reorder stage placed directly after the radix-2 SDF FFT core.
//  The core emits one complex bin per clock in bit-reversed order. This block

---
 rtl/fft_bitrev_reorder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order.
// Frames are written into one bank of a ping-pong buffer while the other bank is replayed.
module fft_bitrev_reorder #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_r,
    input  logic signed [DATA_W-1:0] in_i,
    output logic                     out_valid,
    output logic                     out_sof,
    output logic signed [DATA_W-1:0] out_r,
    output logic signed [DATA_W-1:0] out_i,
    output logic                     frame_err
);

    localparam int N = 1 << LOG2N;

    typedef logic [LOG2N-1:0] cnt_t;

    function automatic cnt_t bitrev(input cnt_t k);
        cnt_t r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = k[LOG2N-1-b];
        end
        return r;
    endfunction

    logic [2*DATA_W-1:0] mem_q [2][N];

    cnt_t wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    cnt_t wr_eff, wr_addr;
    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;
    logic rd_active_q, rd_active_d;
    logic frame_done;
    logic out_valid_q, out_valid_d;
    logic out_sof_q, out_sof_d;
    logic frame_err_q, frame_err_d;
    logic signed [DATA_W-1:0] out_r_q, out_r_d;
    logic signed [DATA_W-1:0] out_i_q, out_i_d;

    always_comb begin
        // A start-of-frame restarts the slot count, discarding any partial frame.
        wr_eff      = (in_valid && in_sof) ? '0 : wr_cnt_q;
        wr_addr     = bitrev(wr_eff);
        frame_done  = in_valid && (&wr_eff);
        frame_err_d = in_valid && in_sof && (wr_cnt_q != '0);
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        if (in_valid) begin
            wr_cnt_d = wr_eff + cnt_t'(1);
            if (frame_done) begin
                wr_bank_d = ~wr_bank_q;
            end
        end

        rd_active_d = rd_active_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        if (rd_active_q) begin
            {out_r_d, out_i_d} = mem_q[rd_bank_q][rd_cnt_q];
            out_valid_d        = 1'b1;
            out_sof_d          = (rd_cnt_q == '0);
            rd_cnt_d           = rd_cnt_q + cnt_t'(1);
            if (&rd_cnt_q) begin
                rd_active_d = 1'b0;
            end
        end
        // A newly completed frame takes over the reader with no bubble.
        if (frame_done) begin
            rd_active_d = 1'b1;
            rd_bank_d   = wr_bank_q;
            rd_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem_q[wr_bank_q][wr_addr] <= {in_r, in_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_active_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            frame_err_q <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_active_q <= rd_active_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            frame_err_q <= frame_err_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign frame_err = frame_err_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;

endmodule
